// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit: sequences MULT/MULTU/DIV/DIVU, owns HI/LO,
// and raises the decode-stage stall for HI/LO-dependent instructions.
module mdu_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             md_use_D,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             md_stall
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   abs_a_s, abs_b_s, div_b_s, uq_s, ur_s;
  logic               a_neg_s, b_neg_s, signed_s;
  logic [WIDTH-1:0]   res_hi_s, res_lo_s;
  logic               wr_en_s;

  // Result datapath, evaluated from the latched operands and used on the final RUN edge.
  always_comb begin
    signed_s = (op_q == OP_MULT[1:0]) || (op_q == OP_DIV[1:0]);
    a_neg_s  = signed_s & a_q[WIDTH-1];
    b_neg_s  = signed_s & b_q[WIDTH-1];
    if (signed_s) begin
      prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    end else begin
      prod_s = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    end
    abs_a_s = a_neg_s ? (~a_q + {{(WIDTH-1){1'b0}}, 1'b1}) : a_q;
    abs_b_s = b_neg_s ? (~b_q + {{(WIDTH-1){1'b0}}, 1'b1}) : b_q;
    // Divisor forced to 1 on divide-by-zero; the write is suppressed anyway.
    div_b_s = (b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b_s;
    uq_s    = abs_a_s / div_b_s;
    ur_s    = abs_a_s % div_b_s;
    if (op_q[1] == 1'b0) begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
      wr_en_s  = 1'b1;
    end else begin
      // Most-negative / -1 falls out naturally: |a| = 2^(W-1), quotient kept positive-encoded.
      res_lo_s = (a_neg_s ^ b_neg_s) ? (~uq_s + {{(WIDTH-1){1'b0}}, 1'b1}) : uq_s;
      res_hi_s = a_neg_s ? (~ur_s + {{(WIDTH-1){1'b0}}, 1'b1}) : ur_s;
      wr_en_s  = (b_q != '0);
    end
  end

  // Control sequencer and HI/LO state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            case (md_op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                op_q    <= md_op[1:0];
                a_q     <= rs_val;
                b_q     <= rt_val;
                cnt_q   <= md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                state_q <= RUN;
              end
              OP_MTHI: hi_q <= rs_val;
              OP_MTLO: lo_q <= rs_val;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
            if (wr_en_s) begin
              hi_q <= res_hi_s;
              lo_q <= res_lo_s;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q == RUN);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign md_stall = md_use_D & (start | busy);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: expected HI/LO pairs are queued at start and
// checked when busy falls; busy length and md_stall are checked every cycle.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        md_use_D;
  logic        busy, md_stall;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  mdu_ctrl #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .md_use_D(md_use_D),
    .busy(busy), .hi(hi), .lo(lo), .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launches an MD op, optionally injects a second start on busy cycle 2,
  // counts busy cycles and checks the queued result when busy falls.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [63:0] exp,
                        input logic use_d, input logic inj, input logic [2:0] inj_op);
    int cnt;
    @(negedge clk);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b; md_use_D = use_d;
    exp_q.push_back(exp);
    #1 check({tag, " stall_start"}, {63'd0, md_stall}, {63'd0, use_d});
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      if (inj && cnt == 1) begin
        start = 1'b1; md_op = inj_op; rs_val = 32'hDEADBEEF; rt_val = 32'h00000009;
      end else begin
        start = 1'b0;
      end
      #1 check({tag, " stall_busy"}, {63'd0, md_stall}, {63'd0, use_d});
      cnt++;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " busy_len"}, 64'(cnt), 64'(n));
    #1 check({tag, " stall_fall"}, {63'd0, md_stall}, 64'd0);
    if (exp_q.size() > 0) check({tag, " hilo"}, {hi, lo}, exp_q.pop_front());
    else check({tag, " queue"}, 64'd1, 64'd0);
    md_use_D = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_val = 32'd0; rt_val = 32'd0; md_use_D = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset hilo", {hi, lo}, 64'd0);
    check("reset stall", {63'd0, md_stall}, 64'd0);

    run_op("mult", 3'd0, 32'hFFFFFFFD, 32'd7, 5, {32'hFFFFFFFF, 32'hFFFFFFEB}, 1'b0, 1'b0, 3'd0);
    run_op("multu", 3'd1, 32'hFFFFFFFF, 32'd2, 5, {32'h00000001, 32'hFFFFFFFE}, 1'b0, 1'b0, 3'd0);
    run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, 10, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 1'b0, 3'd0);
    run_op("divu0", 3'd3, 32'd7, 32'd0, 10, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 1'b0, 3'd0);

    // MTHI while idle
    @(negedge clk);
    start = 1'b1; md_op = 3'd4; rs_val = 32'h00001234;
    @(negedge clk);
    start = 1'b0;
    check("mthi hilo", {hi, lo}, {32'h00001234, 32'hFFFFFFFD});
    check("mthi busy", {63'd0, busy}, 64'd0);

    run_op("mtlo_in_run", 3'd0, 32'd3, 32'd4, 5, {32'd0, 32'd12}, 1'b0, 1'b1, 3'd5);
    run_op("stall_mult", 3'd0, 32'h00010000, 32'h00010000, 5, {32'd1, 32'd0}, 1'b1, 1'b1, 3'd0);
    check("post_inject busy", {63'd0, busy}, 64'd0);

    // Reserved op is ignored
    start = 1'b1; md_op = 3'd6; rs_val = 32'h55555555; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check("rsvd busy", {63'd0, busy}, 64'd0);
    check("rsvd hilo", {hi, lo}, {32'd1, 32'd0});

    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, {32'd0, 32'h80000000}, 1'b0, 1'b0, 3'd0);
    run_op("divu", 3'd3, 32'd100, 32'd7, 10, {32'd2, 32'd14}, 1'b0, 1'b0, 3'd0);

    // Reset asserted during the 3rd busy cycle of a DIV
    @(negedge clk);
    start = 1'b1; md_op = 3'd2; rs_val = 32'd50; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check("rst_mid busy1", {63'd0, busy}, 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid busy", {63'd0, busy}, 64'd0);
    check("rst_mid hilo", {hi, lo}, 64'd0);
    repeat (12) @(negedge clk);
    check("rst_mid late busy", {63'd0, busy}, 64'd0);
    check("rst_mid late hilo", {hi, lo}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
